// File: rtl/axi4_lite_pkg.sv
// Shared constants for the AXI4-Lite register slave: register offsets,
// response codes and the channel FSM state encodings.
package axi4_lite_pkg;

  localparam logic [3:0] OFF_CTRL     = 4'h0;
  localparam logic [3:0] OFF_SCRATCH0 = 4'h4;
  localparam logic [3:0] OFF_SCRATCH1 = 4'h8;
  localparam logic [3:0] OFF_CYCLES   = 4'hC;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE      = 2'd0,
    W_HAVE_ADDR = 2'd1,
    W_HAVE_DATA = 2'd2,
    W_RESP      = 2'd3
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  // The window is 16 bytes, so only address bits [31:4] take part in the match.
  function automatic logic in_window(input logic [31:4] addr, input logic [31:4] base);
    return addr == base;
  endfunction

endpackage

// File: rtl/axi4_lite_strb_merge.sv
// Byte-lane merge: each byte of the result comes from new_data when its
// strobe is set, otherwise from old_data.
module axi4_lite_strb_merge (
  input  logic [31:0] old_data,
  input  logic [31:0] new_data,
  input  logic [3:0]  strb,
  output logic [31:0] merged
);

  // Select each byte lane independently by its strobe.
  always_comb begin
    merged = old_data;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) merged[8*i +: 8] = new_data[8*i +: 8];
    end
  end

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave with a 16-byte register window: CTRL (drives LED),
// two scratch registers and a read-only free-running cycle counter.
//
// Write FSM
//   state       | meaning
//   W_IDLE      | waiting for address and/or data
//   W_HAVE_ADDR | address latched, waiting for data
//   W_HAVE_DATA | data and strobes latched, waiting for address
//   W_RESP      | register updated, BVALID asserted until BREADY
// Read FSM
//   state       | meaning
//   R_IDLE      | ARREADY asserted, waiting for an address
//   R_DATA      | RVALID asserted, RDATA/RRESP held until RREADY
module axi4_lite_slave_regs
  import axi4_lite_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR = 32'h0000_0000,
  parameter int          LED_WIDTH  = 4
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  input  logic [31:0]          S_AXI_AWADDR,
  input  logic [2:0]           S_AXI_AWPROT,
  input  logic                 S_AXI_AWVALID,
  output logic                 S_AXI_AWREADY,
  input  logic [31:0]          S_AXI_WDATA,
  input  logic [3:0]           S_AXI_WSTRB,
  input  logic                 S_AXI_WVALID,
  output logic                 S_AXI_WREADY,
  output logic [1:0]           S_AXI_BRESP,
  output logic                 S_AXI_BVALID,
  input  logic                 S_AXI_BREADY,
  input  logic [31:0]          S_AXI_ARADDR,
  input  logic [2:0]           S_AXI_ARPROT,
  input  logic                 S_AXI_ARVALID,
  output logic                 S_AXI_ARREADY,
  output logic [31:0]          S_AXI_RDATA,
  output logic [1:0]           S_AXI_RRESP,
  output logic                 S_AXI_RVALID,
  input  logic                 S_AXI_RREADY,
  output logic [LED_WIDTH-1:0] LED
);

  // Protection bits and byte offsets within a word carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  w_state_t    w_state, w_next;
  r_state_t    r_state, r_next;
  logic [31:2] aw_addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        aw_ready_q, w_ready_q, b_valid_q, ar_ready_q, r_valid_q;
  logic [1:0]  b_resp_q, r_resp_q;
  logic [31:0] r_data_q;
  logic [31:0] ctrl_q, scratch0_q, scratch1_q, cycles_q;

  logic        aw_hs, w_hs, ar_hs;
  logic        commit, wr_ok;
  logic [31:2] cm_addr;
  logic [31:0] cm_data, cm_old, cm_merged;
  logic [3:0]  cm_strb;
  logic [31:0] rd_val;
  logic [1:0]  rd_resp;

  assign aw_hs = S_AXI_AWVALID && aw_ready_q;
  assign w_hs  = S_AXI_WVALID  && w_ready_q;
  assign ar_hs = S_AXI_ARVALID && ar_ready_q;

  // Write FSM state register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) w_state <= W_IDLE;
    else          w_state <= w_next;
  end

  // Write next-state and selection of the address/data pair being committed.
  always_comb begin
    w_next  = w_state;
    commit  = 1'b0;
    cm_addr = aw_addr_q;
    cm_data = wdata_q;
    cm_strb = wstrb_q;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          w_next  = W_RESP;
          commit  = 1'b1;
          cm_addr = S_AXI_AWADDR[31:2];
          cm_data = S_AXI_WDATA;
          cm_strb = S_AXI_WSTRB;
        end else if (aw_hs) begin
          w_next = W_HAVE_ADDR;
        end else if (w_hs) begin
          w_next = W_HAVE_DATA;
        end
      end
      W_HAVE_ADDR: begin
        if (w_hs) begin
          w_next  = W_RESP;
          commit  = 1'b1;
          cm_data = S_AXI_WDATA;
          cm_strb = S_AXI_WSTRB;
        end
      end
      W_HAVE_DATA: begin
        if (aw_hs) begin
          w_next  = W_RESP;
          commit  = 1'b1;
          cm_addr = S_AXI_AWADDR[31:2];
        end
      end
      W_RESP: begin
        if (b_valid_q && S_AXI_BREADY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Writes are accepted only inside the window and never to the cycle counter.
  assign wr_ok = in_window(cm_addr[31:4], C_BASEADDR[31:4]) && (cm_addr[3:2] != OFF_CYCLES[3:2]);

  // Current value of the targeted register, used as the base for partial writes.
  always_comb begin
    cm_old = 32'h0;
    case (cm_addr[3:2])
      OFF_CTRL[3:2]:     cm_old = ctrl_q;
      OFF_SCRATCH0[3:2]: cm_old = scratch0_q;
      OFF_SCRATCH1[3:2]: cm_old = scratch1_q;
      default:           cm_old = cycles_q;
    endcase
  end

  axi4_lite_strb_merge u_strb_merge (
    .old_data (cm_old),
    .new_data (cm_data),
    .strb     (cm_strb),
    .merged   (cm_merged)
  );

  // Hold whichever half of a write arrived first until its partner shows up.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_addr_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      if (aw_hs) aw_addr_q <= S_AXI_AWADDR[31:2];
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
    end
  end

  // Register file and cycle counter; updates land on the edge entering W_RESP.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ctrl_q     <= '0;
      scratch0_q <= '0;
      scratch1_q <= '0;
      cycles_q   <= '0;
    end else begin
      cycles_q <= cycles_q + 32'd1;
      if (commit && wr_ok) begin
        case (cm_addr[3:2])
          OFF_CTRL[3:2]:     ctrl_q     <= cm_merged;
          OFF_SCRATCH0[3:2]: scratch0_q <= cm_merged;
          OFF_SCRATCH1[3:2]: scratch1_q <= cm_merged;
          default:           ;
        endcase
      end
    end
  end

  // Write channel outputs are registered from the next state so they stay
  // low until the first edge after reset release.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= RESP_OKAY;
    end else begin
      aw_ready_q <= (w_next == W_IDLE) || (w_next == W_HAVE_DATA);
      w_ready_q  <= (w_next == W_IDLE) || (w_next == W_HAVE_ADDR);
      b_valid_q  <= (w_next == W_RESP);
      if (commit) b_resp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Read FSM state register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_state <= R_IDLE;
    else          r_state <= r_next;
  end

  // Read next-state logic.
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (r_valid_q && S_AXI_RREADY) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Read decode from the pre-edge register values, so a same-edge write is not seen.
  always_comb begin
    rd_val  = 32'h0;
    rd_resp = RESP_SLVERR;
    if (in_window(S_AXI_ARADDR[31:4], C_BASEADDR[31:4])) begin
      rd_resp = RESP_OKAY;
      case (S_AXI_ARADDR[3:2])
        OFF_CTRL[3:2]:     rd_val = ctrl_q;
        OFF_SCRATCH0[3:2]: rd_val = scratch0_q;
        OFF_SCRATCH1[3:2]: rd_val = scratch1_q;
        default:           rd_val = cycles_q;
      endcase
    end
  end

  // Read channel outputs; data is captured at the AR handshake and held.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
      r_resp_q   <= RESP_OKAY;
    end else begin
      ar_ready_q <= (r_next == R_IDLE);
      r_valid_q  <= (r_next == R_DATA);
      if (ar_hs) begin
        r_data_q <= rd_val;
        r_resp_q <= rd_resp;
      end
    end
  end

  assign S_AXI_AWREADY = aw_ready_q;
  assign S_AXI_WREADY  = w_ready_q;
  assign S_AXI_BVALID  = b_valid_q;
  assign S_AXI_BRESP   = b_resp_q;
  assign S_AXI_ARREADY = ar_ready_q;
  assign S_AXI_RVALID  = r_valid_q;
  assign S_AXI_RDATA   = r_data_q;
  assign S_AXI_RRESP   = r_resp_q;
  assign LED           = ctrl_q[LED_WIDTH-1:0];

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// word-array model of the register window.
module tb_axi4_lite_slave_regs;

  localparam logic [31:0] BASE = 32'h4000_0010;

  logic        ACLK, ARESETN;
  logic [31:0] S_AXI_AWADDR, S_AXI_WDATA, S_AXI_ARADDR, S_AXI_RDATA;
  logic [2:0]  S_AXI_AWPROT, S_AXI_ARPROT;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
  logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic        S_AXI_RVALID, S_AXI_RREADY;
  logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
  logic [3:0]  LED;

  axi4_lite_slave_regs #(.C_BASEADDR(BASE), .LED_WIDTH(4)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .LED(LED)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int errors = 0;
  int checks = 0;
  logic [31:0] mreg [3];
  logic [31:0] last_cycles;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  function automatic bit in_win(input logic [31:0] a);
    return a >= BASE && a < BASE + 32'd16;
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a - BASE) / 32'd4);
  endfunction

  function automatic logic [1:0] exp_wresp(input logic [31:0] a);
    if (in_win(a) && word_of(a) < 3) return 2'b00;
    return 2'b10;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) mreg[i] = 32'h0;
    last_cycles = 32'h0;
  endtask

  // Issue one write with independent AW/W start delays and a B-ready delay.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly,
                          input int b_dly);
    bit aw_done = 0, w_done = 0, awh, wh;
    int cyc = 0;
    logic [1:0] eresp;
    eresp = exp_wresp(addr);
    S_AXI_AWADDR = addr;
    S_AXI_WDATA  = data;
    S_AXI_WSTRB  = strb;
    while (!(aw_done && w_done) && cyc < 50) begin
      S_AXI_AWVALID = !aw_done && (cyc >= aw_dly);
      S_AXI_WVALID  = !w_done && (cyc >= w_dly);
      awh = S_AXI_AWVALID && S_AXI_AWREADY;
      wh  = S_AXI_WVALID && S_AXI_WREADY;
      step();
      if (awh) aw_done = 1;
      if (wh) w_done = 1;
      cyc++;
    end
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    chk("wr_handshakes", {31'b0, aw_done && w_done}, 32'd1);
    if (!(aw_done && w_done)) return;
    chk("bvalid_latency", {31'b0, S_AXI_BVALID}, 32'd1);
    chk("bresp", {30'b0, S_AXI_BRESP}, {30'b0, eresp});
    if (eresp == 2'b00) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) mreg[word_of(addr)][8*b +: 8] = data[8*b +: 8];
    end
    for (int i = 0; i < b_dly; i++) begin
      step();
      chk("bvalid_hold", {31'b0, S_AXI_BVALID}, 32'd1);
      chk("bresp_hold", {30'b0, S_AXI_BRESP}, {30'b0, eresp});
    end
    S_AXI_BREADY = 1'b1;
    step();
    S_AXI_BREADY = 1'b0;
    chk("bvalid_drop", {31'b0, S_AXI_BVALID}, 32'd0);
  endtask

  // Issue one read, hold RREADY low for r_dly cycles, check data against the model.
  task automatic do_read(input logic [31:0] addr, input int r_dly);
    bit arh = 0;
    int cyc = 0;
    logic [31:0] edata, got;
    logic [1:0]  eresp;
    bit is_cycles;
    is_cycles = in_win(addr) && word_of(addr) == 3;
    eresp = in_win(addr) ? 2'b00 : 2'b10;
    edata = (in_win(addr) && !is_cycles) ? mreg[word_of(addr)] : 32'h0;
    S_AXI_ARADDR  = addr;
    S_AXI_ARVALID = 1'b1;
    while (!arh && cyc < 50) begin
      arh = S_AXI_ARREADY;
      step();
      cyc++;
    end
    S_AXI_ARVALID = 1'b0;
    chk("rd_handshake", {31'b0, arh}, 32'd1);
    if (!arh) return;
    chk("rvalid_latency", {31'b0, S_AXI_RVALID}, 32'd1);
    chk("rresp", {30'b0, S_AXI_RRESP}, {30'b0, eresp});
    got = S_AXI_RDATA;
    if (is_cycles) begin
      chk("cycles_increase", {31'b0, got > last_cycles}, 32'd1);
      last_cycles = got;
      edata = got;
    end else begin
      chk("rdata", got, edata);
    end
    for (int i = 0; i < r_dly; i++) begin
      step();
      chk("rvalid_hold", {31'b0, S_AXI_RVALID}, 32'd1);
      chk("rdata_hold", S_AXI_RDATA, edata);
    end
    S_AXI_RREADY = 1'b1;
    step();
    S_AXI_RREADY = 1'b0;
    chk("rvalid_drop", {31'b0, S_AXI_RVALID}, 32'd0);
  endtask

  task automatic chk_led();
    chk("led", {28'b0, LED}, mreg[0] & 32'hF);
  endtask

  initial begin
    logic [31:0] a, d, old;
    int sel;

    ARESETN = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0;  S_AXI_WSTRB = '0;  S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b0;
    model_reset();
    repeat (3) step();
    chk("reset_outputs", {25'b0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY,
                          S_AXI_BVALID, S_AXI_RVALID, S_AXI_BRESP | S_AXI_RRESP} | S_AXI_RDATA | {28'b0, LED},
        32'h0);
    ARESETN = 1'b1;
    #1;
    chk("ready_low_before_edge", {29'b0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'h0);
    step();
    chk("ready_after_edge", {29'b0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'h7);

    // CTRL write drives LED.
    do_write(BASE + 32'h0, 32'h0000_000A, 4'hF, 0, 0, 0);
    do_read(BASE + 32'h0, 0);
    chk_led();

    // Partial-strobe merge on SCRATCH0.
    do_write(BASE + 32'h4, 32'h1122_3344, 4'hF, 0, 0, 0);
    do_write(BASE + 32'h4, 32'hAABB_CCDD, 4'b0101, 0, 0, 0);
    do_read(BASE + 32'h4, 0);
    chk("scratch0_merge", mreg[1], 32'h11BB_33DD);

    // Data leading address, then address leading data.
    do_write(BASE + 32'h8, 32'hCAFE_0001, 4'hF, 3, 0, 0);
    do_write(BASE + 32'h8, 32'hCAFE_0002, 4'hF, 0, 3, 0);
    do_read(BASE + 32'h8, 0);

    // Error responses leave the registers untouched.
    do_write(BASE + 32'hC, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    do_write(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    do_read(BASE + 32'h10, 0);
    do_read(BASE + 32'h0, 0);
    do_read(BASE + 32'h4, 0);
    do_read(BASE + 32'h8, 0);

    // Back-pressure on B and R, then CYCLES twice.
    do_write(BASE + 32'h4, 32'h5555_AAAA, 4'hF, 0, 0, 5);
    do_read(BASE + 32'h4, 5);
    do_read(BASE + 32'hC, 5);
    do_read(BASE + 32'hC, 0);

    // Concurrent read and write of the same register: read sees the old value.
    old = mreg[2];
    S_AXI_AWADDR = BASE + 32'h8; S_AXI_WDATA = 32'h0BAD_F00D; S_AXI_WSTRB = 4'hF;
    S_AXI_ARADDR = BASE + 32'h8;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
    step();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    chk("conc_rvalid", {31'b0, S_AXI_RVALID}, 32'd1);
    chk("conc_bvalid", {31'b0, S_AXI_BVALID}, 32'd1);
    chk("conc_rdata_old", S_AXI_RDATA, old);
    mreg[2] = 32'h0BAD_F00D;
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    step();
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    do_read(BASE + 32'h8, 0);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 8)       a = BASE + {28'b0, 4'($urandom_range(0, 15))};
      else if (sel == 8) a = BASE + 32'h10 + 32'($urandom_range(0, 255));
      else               a = $urandom;
      d = $urandom;
      if ($urandom_range(0, 1) == 0)
        do_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3));
      else
        do_read(a, $urandom_range(0, 3));
    end
    chk_led();

    // Reset while holding an address waiting for data.
    do_write(BASE + 32'h0, 32'h0000_0005, 4'hF, 0, 0, 0);
    S_AXI_AWADDR = BASE + 32'h0;
    S_AXI_AWVALID = 1'b1;
    step();
    S_AXI_AWVALID = 1'b0;
    #2;
    ARESETN = 1'b0;
    #1;
    chk("midreset_outputs", {25'b0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY,
                             S_AXI_BVALID, S_AXI_RVALID, S_AXI_BRESP | S_AXI_RRESP} | S_AXI_RDATA | {28'b0, LED},
        32'h0);
    model_reset();
    repeat (2) step();
    ARESETN = 1'b1;
    step();
    chk("bvalid_after_reset", {31'b0, S_AXI_BVALID}, 32'd0);
    do_read(BASE + 32'h0, 0);
    chk_led();
    do_read(BASE + 32'hC, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi4_lite_slave_regs.md
AXI4_LITE_SLAVE_REGS -- requirements
Module: axi4_lite_slave_regs

Interface
REQ-001 SHALL have parameter C_BASEADDR, default 32'h0000_0000: base of the 16-byte register window; must be 16-byte aligned.
REQ-002 SHALL have parameter LED_WIDTH, default 4: width of the LED output, range 1..32.
REQ-003 SHALL have one clock; reset is asynchronous and active-low; ports are ACLK and ARESETN.
REQ-004 SHALL have ports (name direction width meaning):
- ACLK in 1: clock, all logic on the rising edge.
- ARESETN in 1: asynchronous active-low reset.
- S_AXI_AWADDR in 32 / S_AXI_AWPROT in 3 / S_AXI_AWVALID in 1 / S_AXI_AWREADY out 1: write address channel; AWPROT is ignored.
- S_AXI_WDATA in 32 / S_AXI_WSTRB in 4 / S_AXI_WVALID in 1 / S_AXI_WREADY out 1: write data channel.
- S_AXI_BRESP out 2 / S_AXI_BVALID out 1 / S_AXI_BREADY in 1: write response channel.
- S_AXI_ARADDR in 32 / S_AXI_ARPROT in 3 / S_AXI_ARVALID in 1 / S_AXI_ARREADY out 1: read address channel; ARPROT is ignored.
- S_AXI_RDATA out 32 / S_AXI_RRESP out 2 / S_AXI_RVALID out 1 / S_AXI_RREADY in 1: read data channel.
- LED out LED_WIDTH: REG0[LED_WIDTH-1:0], driven from a register.

Function
REQ-005 SHALL implement the register map, indexed by ADDR[3:2]:
- 0x0 CTRL: RW, reset 0.
- 0x4 SCRATCH0: RW, reset 0.
- 0x8 SCRATCH1: RW, reset 0.
- 0xC CYCLES: RO, free-running 32-bit cycle counter, reset 0, wraps FFFF_FFFF->0.
REQ-006 SHALL decode an address as in-window when ADDR[31:4]==C_BASEADDR[31:4]; ADDR[1:0] are ignored.
REQ-007 SHALL run the write FSM with states W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP.
REQ-008 SHALL assert AWREADY only in W_IDLE and W_HAVE_DATA, and WREADY only in W_IDLE and W_HAVE_ADDR.
REQ-009 SHALL make these write FSM transitions:
- W_IDLE, AW and W handshakes in the same cycle -> W_RESP.
- W_IDLE, AW only -> W_HAVE_ADDR, address latched.
- W_IDLE, W only -> W_HAVE_DATA, data and strobes latched.
- W_HAVE_ADDR on W handshake, or W_HAVE_DATA on AW handshake -> W_RESP.
REQ-010 SHALL update the target register on the clock edge that enters W_RESP, per byte lane: byte n is written only when WSTRB[n]=1.
REQ-011 SHALL assert BVALID exactly while in W_RESP and hold BRESP stable there; W_RESP -> W_IDLE on BVALID&&BREADY.
REQ-012 SHALL return BRESP OKAY(00) for an in-window write to 0x0/0x4/0x8.
REQ-013 SHALL return BRESP SLVERR(10) for a write to CYCLES or to an out-of-window address; no register changes.
REQ-014 SHALL run the read FSM with states R_IDLE (ARREADY=1) and R_DATA (RVALID=1).
REQ-015 SHALL, on the AR handshake, register RDATA/RRESP from the values before any same-edge write, then go to R_DATA; R_DATA -> R_IDLE on RVALID&&RREADY.
REQ-016 SHALL hold RDATA/RRESP stable while RVALID=1 and RREADY=0; CYCLES is sampled at the AR handshake, not at the R handshake.
REQ-017 SHALL return RRESP OKAY for an in-window read; out-of-window reads return RDATA=0, RRESP SLVERR.
REQ-018 SHALL run the read and write FSMs independently; a concurrent read and write to the same register is legal, and the read returns the old value.
REQ-019 SHALL give a minimum latency of 1 cycle from the AW+W handshake to BVALID and 1 cycle from the AR handshake to RVALID; the slave inserts no added waits.
REQ-020 SHALL keep VALID outputs independent of READY inputs combinationally; all channel outputs are registered.

Reset
REQ-021 SHALL, on ARESETN=0, at once force:
- AWREADY/WREADY/ARREADY/BVALID/RVALID=0, BRESP/RRESP=00, RDATA=0, LED=0.
- all registers 0; FSMs to W_IDLE/R_IDLE.
REQ-022 SHALL, on reset mid-transaction, abandon it with no response and make no partial register update.
REQ-023 SHALL raise AWREADY/WREADY/ARREADY no earlier than the first rising ACLK after ARESETN deasserts.

Structure
REQ-024 SHALL keep the register offsets, RESP codes (OKAY/EXOKAY/SLVERR/DECERR) and FSM state encodings in the shared package axi4_lite_pkg.
REQ-025 SHALL use one sub-module, axi4_lite_strb_merge: a combinational byte-lane merge of old data, new data and WSTRB.

Verification
REQ-026 SHALL check: write 0x0=0000_000A, WSTRB=F -> BRESP 00; read 0x0 -> 0000_000A; LED=4'hA.
REQ-027 SHALL check: write 0x4=1122_3344, then write 0x4=AABB_CCDD with WSTRB=0101 -> read 0x4 = 11BB_33DD.
REQ-028 SHALL check: W presented 3 cycles before AW, then AW before W -> both complete, BVALID 1 cycle after the second handshake.
REQ-029 SHALL check: write to 0xC, and a read/write at C_BASEADDR+0x10 -> SLVERR; registers unchanged; that read returns 0.
REQ-030 SHALL check: BREADY held low 5 cycles and RREADY held low 5 cycles -> BVALID/RVALID held with stable BRESP/RDATA; the next AR read of CYCLES is greater than the earlier one.
REQ-031 SHALL check: ARESETN pulsed low while in W_HAVE_ADDR -> all outputs 0 immediately; a later read of 0x0 returns 0.
